// File: rtl/salsa_engine.sv
// salsa_engine: Salsa20/ROUNDS permutation engine with valid/ready handshaking.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_data is valid
//   in_ready   engine accepts in_data this cycle
//   in_data    sixteen 32-bit words, word i at bits [32i+31:32i]
//   out_valid  out_data and xaddr are valid (state DONE)
//   out_ready  consumer takes the result
//   out_data   result words, same word order as in_data
//   xaddr      registered copy of out_data[ADDR_W-1:0]
//   busy       high while a block is in RUN or DONE
//
// Configuration macro SALSA_FEEDFORWARD_EN: when defined, out_data is the
// permuted state plus the latched input (full Salsa20 hash); otherwise out_data
// is the raw permuted state and no feed-forward register is built.
module salsa_engine #(
    parameter int ROUNDS = 8,
    parameter int UNROLL = 1,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [511:0]      in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [511:0]      out_data,
    output logic [ADDR_W-1:0] xaddr,
    output logic              busy
);
    localparam int ITERS = (UNROLL > 0) ? ROUNDS / (2 * UNROLL) : 1;
    localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

    generate
        if (ROUNDS < 2 || ROUNDS % 2 != 0 || UNROLL < 1 || (ROUNDS / 2) % UNROLL != 0 ||
            ADDR_W < 1 || ADDR_W > 512) begin : g_bad
            $error("salsa_engine: ROUNDS must be even and >= 2, UNROLL must divide ROUNDS/2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [511:0]  x, perm, result;
    logic [CW-1:0] cnt;
    logic          live;
    logic          take_in, take_out;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Quarter-rounds 0..3 are the columns, 4..7 the rows. Both sets start at
    // the diagonal word 5g; the other three indices are derived from g.
    function automatic logic [511:0] double_round(input logic [511:0] s);
        logic [31:0]  w [16];
        logic [511:0] r;
        int g, a, b, c, d;
        for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
        for (int k = 0; k < 8; k++) begin
            g = k % 4;
            a = 5 * g;
            b = (k < 4) ? (a + 4) % 16  : 4 * g + (g + 1) % 4;
            c = (k < 4) ? (a + 8) % 16  : 4 * g + (g + 2) % 4;
            d = (k < 4) ? (a + 12) % 16 : 4 * g + (g + 3) % 4;
            w[b] ^= rotl(w[a] + w[d], 7);
            w[c] ^= rotl(w[b] + w[a], 9);
            w[d] ^= rotl(w[c] + w[b], 13);
            w[a] ^= rotl(w[d] + w[c], 18);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    always_comb begin
        perm = x;
        for (int u = 0; u < UNROLL; u++) perm = double_round(perm);
    end

`ifdef SALSA_FEEDFORWARD_EN
    logic [511:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else if (take_in) ff <= in_data;
    end

    for (genvar i = 0; i < 16; i++) begin : g_ff
        assign result[32*i +: 32] = perm[32*i +: 32] + ff[32*i +: 32];
    end
`else
    assign result = perm;
`endif

    // live holds in_ready low during reset and releases it on the first edge after.
    assign in_ready  = live && (state == IDLE || (state == DONE && out_ready));
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign take_in   = in_valid && in_ready;
    assign take_out  = out_valid && out_ready;

    always_comb begin
        state_nx = state;
        if (take_in) state_nx = RUN;
        else if (state == RUN && cnt == '0) state_nx = DONE;
        else if (take_out) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            live     <= 1'b0;
            x        <= '0;
            cnt      <= '0;
            out_data <= '0;
            xaddr    <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (take_in) begin
                x   <= in_data;
                cnt <= CW'(ITERS - 1);
            end else if (state == RUN) begin
                x   <= perm;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    out_data <= result;
                    xaddr    <= result[ADDR_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_salsa_engine.sv
// tb_salsa_engine: randomized self-checking bench for salsa_engine against a transaction-level Salsa20 model.
module tb_salsa_engine;
`ifdef SALSA_FEEDFORWARD_EN
    localparam bit FF = 1'b1;
`else
    localparam bit FF = 1'b0;
`endif
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [511:0] in_data, out_data;
    logic [9:0]   xaddr;

    logic         e_iv [2];
    logic         e_ir [2];
    logic         e_ov [2];
    logic         e_busy [2];
    logic [511:0] e_id [2];
    logic [511:0] e_od [2];
    logic [9:0]   e_xa [2];

    int pass_n = 0;
    int total_n = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    salsa_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .xaddr(xaddr), .busy(busy)
    );

    for (genvar g = 0; g < 2; g++) begin : g_ext
        salsa_engine #(.ROUNDS(g == 0 ? 20 : 8), .UNROLL(g == 0 ? 2 : 4)) u (
            .clk(clk), .rst_n(rst_n), .in_valid(e_iv[g]), .in_ready(e_ir[g]), .in_data(e_id[g]),
            .out_valid(e_ov[g]), .out_ready(1'b1), .out_data(e_od[g]), .xaddr(e_xa[g]), .busy(e_busy[g])
        );
    end

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // Straight transcription of the scrypt salsa20 core.
    function automatic logic [511:0] salsa_ref(input logic [511:0] b, input int rounds, input bit ff);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = b[32*i +: 32];
        for (int k = 0; k < rounds; k += 2) begin
            x[ 4] ^= rl(x[ 0] + x[12], 7);  x[ 8] ^= rl(x[ 4] + x[ 0], 9);
            x[12] ^= rl(x[ 8] + x[ 4], 13); x[ 0] ^= rl(x[12] + x[ 8], 18);
            x[ 9] ^= rl(x[ 5] + x[ 1], 7);  x[13] ^= rl(x[ 9] + x[ 5], 9);
            x[ 1] ^= rl(x[13] + x[ 9], 13); x[ 5] ^= rl(x[ 1] + x[13], 18);
            x[14] ^= rl(x[10] + x[ 6], 7);  x[ 2] ^= rl(x[14] + x[10], 9);
            x[ 6] ^= rl(x[ 2] + x[14], 13); x[10] ^= rl(x[ 6] + x[ 2], 18);
            x[ 3] ^= rl(x[15] + x[11], 7);  x[ 7] ^= rl(x[ 3] + x[15], 9);
            x[11] ^= rl(x[ 7] + x[ 3], 13); x[15] ^= rl(x[11] + x[ 7], 18);
            x[ 1] ^= rl(x[ 0] + x[ 3], 7);  x[ 2] ^= rl(x[ 1] + x[ 0], 9);
            x[ 3] ^= rl(x[ 2] + x[ 1], 13); x[ 0] ^= rl(x[ 3] + x[ 2], 18);
            x[ 6] ^= rl(x[ 5] + x[ 4], 7);  x[ 7] ^= rl(x[ 6] + x[ 5], 9);
            x[ 4] ^= rl(x[ 7] + x[ 6], 13); x[ 5] ^= rl(x[ 4] + x[ 7], 18);
            x[11] ^= rl(x[10] + x[ 9], 7);  x[ 8] ^= rl(x[11] + x[10], 9);
            x[ 9] ^= rl(x[ 8] + x[11], 13); x[10] ^= rl(x[ 9] + x[ 8], 18);
            x[12] ^= rl(x[15] + x[14], 7);  x[13] ^= rl(x[12] + x[15], 9);
            x[14] ^= rl(x[13] + x[12], 13); x[15] ^= rl(x[14] + x[13], 18);
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = ff ? x[i] + b[32*i +: 32] : x[i];
        return r;
    endfunction

    function automatic logic [511:0] from_bytes(input logic [511:0] s);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = s[511-8*k -: 8];
        return r;
    endfunction

    function automatic logic [511:0] wsub(input logic [511:0] a, input logic [511:0] b);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = a[32*i +: 32] - b[32*i +: 32];
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Transaction-level model: at most one block in flight, accepted at cycle bt,
    // whose result is visible from cycle bt+LAT until the consumer takes it.
    bit           m_have = 0;
    bit           m_live = 0;
    int           m_bt = 0;
    logic [511:0] m_res = '0;
    logic [511:0] m_last = '0;

    always @(negedge clk) begin
        logic         ev, er;
        logic [511:0] ed;
        if (!rst_n) begin
            m_have = 0; m_live = 0; m_last = '0;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_xaddr", xaddr, 0);
        end else begin
            ev = m_have && (cyc >= m_bt + LAT);
            ed = ev ? m_res : m_last;
            er = m_live && (!m_have || (ev && out_ready));
            chk("in_ready", in_ready, er);
            chk("out_valid", out_valid, ev);
            chk("busy", busy, m_have);
            chk("out_data", out_data, ed);
            chk("xaddr", xaddr, ed[9:0]);
            if (ev && out_ready) begin m_last = m_res; m_have = 0; end
            if (er && in_valid) begin m_have = 1; m_bt = cyc + 1; m_res = salsa_ref(in_data, 8, FF); end
            m_live = 1;
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    // Offer d until accepted, then count edges until out_valid is seen.
    task automatic run_one(input logic [511:0] d, output logic [511:0] got, output int n);
        bit ok = 0;
        in_valid = 1; in_data = d;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else cycle();
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (out_valid) break;
        end
        got = out_data;
    endtask

    task automatic ext_test(input int g, input int rounds, input int lat);
        logic [511:0] d;
        int n;
        for (int b = 0; b < 3; b++) begin
            d = (b == 0) ? '0 : rnd512();
            cycle();
            e_id[g] = d; e_iv[g] = 1;
            @(negedge clk);
            chk("ext_in_ready", e_ir[g], 1);
            cycle();
            e_iv[g] = 0;
            n = 0;
            for (int t = 0; t < 30; t++) begin
                @(posedge clk); n++;
                @(negedge clk);
                if (e_ov[g]) break;
            end
            chk($sformatf("ext%0d_latency", g), n, lat);
            chk($sformatf("ext%0d_data", g), e_od[g], salsa_ref(d, rounds, FF));
            chk($sformatf("ext%0d_xaddr", g), e_xa[g], salsa_ref(d, rounds, FF) & 512'h3ff);
            cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_n, total_n);
        $fatal(1);
    end

    initial begin
        logic [511:0] rfc_in, rfc_out, got, d;
        int n, last, nout;
        in_valid = 0; out_ready = 1; in_data = '0;
        for (int g = 0; g < 2; g++) begin e_iv[g] = 0; e_id[g] = '0; end
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1;
        cycle();

        rfc_in  = from_bytes(512'h7e879a214f3ec9867ca940e641718f26baee555b8c61c1b50df846116dcd3b1dee24f319df9b3d8514121e4b5ac5aa3276021d2909c74829edebc68db8b8c25e);
        rfc_out = from_bytes(512'ha41f859c6608cc993b81cacb020cef05044b2181a2fd337dfd7b1c6396682f29b4393168e3c9e6bcfe6bc5b7a06d96bae424cc102c91745c24ad673dc7618f81);
        chk("model_rfc", salsa_ref(rfc_in, 8, 1'b1), rfc_out);
        chk("model_zero", salsa_ref('0, 8, 1'b1), '0);

        run_one('0, got, n);
        chk("zero_latency", n, 4);
        chk("zero_data", got, '0);
        chk("zero_xaddr", xaddr, 0);
        cycle();

        run_one(rfc_in, got, n);
        chk("rfc_latency", n, 4);
        chk("rfc_data", got, FF ? rfc_out : wsub(rfc_out, rfc_in));
        cycle();

        repeat (300) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data = rnd512();
            cycle();
        end

        in_valid = 0; out_ready = 1;
        repeat (6) cycle();
        in_valid = 1; in_data = rnd512(); out_ready = 0;
        cycle();
        repeat (14) begin in_data = rnd512(); cycle(); end
        in_valid = 0; out_ready = 1;
        repeat (4) cycle();

        in_valid = 1; in_data = rnd512(); last = -1; nout = 0;
        for (int c = 0; c < 42; c++) begin
            @(negedge clk);
            if (out_valid) begin
                if (last >= 0) chk("stream_gap", c - last, 5);
                last = c; nout++;
            end
            @(posedge clk); #1;
            in_data = rnd512();
        end
        chk("stream_count", nout, 8);
        in_valid = 0;
        repeat (8) cycle();

        in_valid = 1; in_data = rnd512();
        cycle();
        in_valid = 0;
        @(posedge clk); #3 rst_n = 0;
        @(posedge clk); #3 rst_n = 1;
        @(negedge clk);
        chk("post_rst_data", out_data, '0);
        chk("post_rst_valid", out_valid, 0);
        repeat (8) cycle();
        d = rnd512();
        run_one(d, got, n);
        chk("post_rst_latency", n, 4);
        chk("post_rst_result", got, salsa_ref(d, 8, FF));
        repeat (4) cycle();

        ext_test(0, 20, 5);
        ext_test(1, 8, 1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule

// File: doc/salsa_engine.md
SALSA_ENGINE -- requirements
Module: salsa_engine

Interface
REQ-001 SHALL have parameter ROUNDS, default 8: Salsa20 rounds; must be even and >= 2.
REQ-002 SHALL have parameter UNROLL, default 1: double rounds per clock; must divide ROUNDS/2.
REQ-003 SHALL have parameter ADDR_W, default 10: width of xaddr.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1: engine accepts in_data this cycle.
REQ-008 SHALL have port in_data, input, 512: sixteen 32-bit words; word i is bits [32i+31:32i].
REQ-009 SHALL have port out_valid, output, 1: out_data and xaddr are valid.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-011 SHALL have port out_data, output, 512: result words, same word order as in_data.
REQ-012 SHALL have port xaddr, output, ADDR_W: registered copy of out_data[ADDR_W-1:0].
REQ-013 SHALL have port busy, output, 1: high in RUN or DONE.

Function
REQ-014 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-015 SHALL transfer an input when in_valid and in_ready are both high on a rising edge: latch in_data into the state register and the feed-forward register, load round counter = ROUNDS/(2*UNROLL)-1, and move to RUN.
REQ-016 SHALL, in RUN, apply UNROLL double rounds per cycle, each a column round then a row round, with quarter-round rotates 7/9/13/18.
REQ-017 SHALL perform every add as a 32-bit word-wise add modulo 2^32, with no inter-word carry.
REQ-018 SHALL move to DONE and assert out_valid after the cycle in which the counter is 0, so out_valid rises exactly ROUNDS/(2*UNROLL) cycles after the accepting edge (4 cycles at the defaults).
REQ-019 SHALL hold out_data, xaddr and out_valid stable in DONE until out_ready is high on a rising edge.
REQ-020 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-021 SHALL, when an output transfer and an input transfer occur on the same edge, go DONE->RUN directly with no bubble.
REQ-022 SHALL, on an output transfer with no input transfer, go to IDLE and deassert out_valid.
REQ-023 SHALL ignore in_valid while in RUN; in_data is not sampled.
REQ-024 SHALL reject illegal ROUNDS/UNROLL combinations with an elaboration-time error.

Reset
REQ-025 SHALL, on rst_n low, immediately force state=IDLE and out_valid=0, and clear busy, out_data, xaddr, the counter and the feed-forward register to 0.
REQ-026 SHALL, when rst_n asserts mid-RUN or in DONE, discard the in-flight block with no later output.
REQ-027 SHALL hold in_ready=0 while rst_n is low and drive in_ready=1 on the first edge after deassertion.

Configuration
REQ-028 SHALL, when macro SALSA_FEEDFORWARD_EN is defined, set out_data = permuted state + latched input, word-wise modulo 2^32 (full Salsa20/ROUNDS hash).
REQ-029 SHALL, when SALSA_FEEDFORWARD_EN is undefined, set out_data = raw permuted state, omit the feed-forward register, and keep latency and handshake identical.

Verification
REQ-030 SHALL cover: defaults, in_data=0, out_ready=1 -> out_valid exactly 4 cycles after acceptance, out_data=0, xaddr=0, in both macro settings.
REQ-031 SHALL cover: defaults, macro defined, random in_data -> out_data matches the C reference Salsa20/8 (scrypt BlockMix core) bit-exact; with macro undefined -> matches reference minus feed-forward.
REQ-032 SHALL cover: ROUNDS=20, UNROLL=2 -> latency 5 cycles; ROUNDS=8, UNROLL=4 -> latency 1 cycle; results match the reference.
REQ-033 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_data/xaddr unchanged and in_ready=0 throughout; on release, one transfer only.
REQ-034 SHALL cover: continuous in_valid and out_ready over 8 blocks -> one result every 5 cycles at defaults (4 RUN + 1 DONE/accept overlap), all outputs correct and in order.
REQ-035 SHALL cover: rst_n pulsed low during the 2nd RUN cycle -> out_valid stays 0, all outputs read 0, and the next accepted block completes correctly.
